// File: rtl/encoder_pkg.sv
// Shared constants and helpers for the quadrature encoder bring-up loop.
package encoder_pkg;

   localparam logic DIR_CW  = 1'b0;
   localparam logic DIR_CCW = 1'b1;

   localparam int DEFAULT_STEP_PERIOD = 50000;

   // Timer width for a given period; never narrower than one bit.
   function automatic int timer_width(input int period);
      return (period > 2) ? $clog2(period) : 1;
   endfunction

   localparam int TIMER_W = timer_width(DEFAULT_STEP_PERIOD);

   // {A,B} for phase index 0..3; walking the index upward is clockwise (A leads).
   localparam logic [1:0] GRAY_SEQ [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

   function automatic logic [1:0] gray_index(input logic [1:0] ab);
      case (ab)
         2'b00:   return 2'd0;
         2'b10:   return 2'd1;
         2'b11:   return 2'd2;
         default: return 2'd3;
      endcase
   endfunction

endpackage

// File: rtl/quadrature_decoder.sv
// Decodes registered quadrature A/B into a signed position, last direction and a step strobe.
module quadrature_decoder
   import encoder_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        A,
   input  logic        B,
   output logic [31:0] count,
   output logic        dir,
   output logic        step
);

   logic [1:0] prev_ab;
   logic [1:0] delta;

   // Phase distance modulo 4: 1 is a CW step, 3 a CCW step, 0 or 2 carry no usable motion.
   always_comb begin
      delta = gray_index({A, B}) - gray_index(prev_ab);
   end

   // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_ab <= 2'b00;
         count   <= '0;
         dir     <= DIR_CW;
         step    <= 1'b0;
      end else begin
         prev_ab <= {A, B};
         step    <= 1'b0;
         if (delta == 2'd1) begin
            count <= count + 32'd1;
            dir   <= DIR_CW;
            step  <= 1'b1;
         end else if (delta == 2'd3) begin
            count <= count - 32'd1;
            dir   <= DIR_CCW;
            step  <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/encoder_control_system.sv
// Step timer, quadrature phase generator and segment/auto-reverse control around the decoder.
module encoder_control_system
   import encoder_pkg::*;
#(
   parameter int STEP_PERIOD = DEFAULT_STEP_PERIOD
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable_motor_in,
   input  logic        motor_dir_in,
   input  logic [7:0]  limit_value_in,
   output logic        A_out,
   output logic        B_out,
   output logic [31:0] step_count_out,
   output logic        direction_out,
   output logic        done_out,
   output logic        motor_dir_out
);

   localparam int TW = (STEP_PERIOD == DEFAULT_STEP_PERIOD) ? TIMER_W : timer_width(STEP_PERIOD);
   localparam logic [TW-1:0] TERMINAL = TW'(STEP_PERIOD - 1);

   logic [TW-1:0] timer;
   logic          tick;
   logic [1:0]    phase;
   logic [1:0]    phase_next;
   logic [7:0]    seg;
   logic          dir_in_q;
   logic          dec_step;

   assign tick       = enable_motor_in && (timer == TERMINAL);
   assign phase_next = (motor_dir_out == DIR_CW) ? phase + 2'd1 : phase - 2'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         timer <= '0;
      end else if (!enable_motor_in || tick) begin
         timer <= '0;
      end else begin
         timer <= timer + TW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase <= 2'd0;
         A_out <= 1'b0;
         B_out <= 1'b0;
      end else if (tick) begin
         phase <= phase_next;
         A_out <= GRAY_SEQ[phase_next][1];
         B_out <= GRAY_SEQ[phase_next][0];
      end
   end

   quadrature_decoder u_decoder (
      .clk   (clk),
      .rst_n (rst_n),
      .A     (A_out),
      .B     (B_out),
      .count (step_count_out),
      .dir   (direction_out),
      .step  (dec_step)
   );

   // A commanded direction change wins over a same-cycle segment completion.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dir_in_q      <= DIR_CW;
         motor_dir_out <= DIR_CW;
         seg           <= '0;
         done_out      <= 1'b0;
      end else begin
         dir_in_q <= motor_dir_in;
         done_out <= 1'b0;
         if (motor_dir_in != dir_in_q) begin
            motor_dir_out <= motor_dir_in;
            seg           <= '0;
         end else if (enable_motor_in && (limit_value_in != 8'd0) && (seg >= limit_value_in)) begin
            done_out      <= 1'b1;
            motor_dir_out <= ~motor_dir_out;
            seg           <= '0;
         end else if (dec_step) begin
            seg <= seg + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_encoder_control_system.sv
// Self-checking bench: step-level reference model of the encoder loop with randomized segments.
module tb_encoder_control_system;

   localparam int STEP = 50;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable_motor_in;
   logic        motor_dir_in;
   logic [7:0]  limit_value_in;
   logic        A_out;
   logic        B_out;
   logic [31:0] step_count_out;
   logic        direction_out;
   logic        done_out;
   logic        motor_dir_out;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   int exp_done = 0;

   // Reference model state: position, phase index, drive direction, steps in segment, limit.
   int   m_pos   = 0;
   int   m_phase = 0;
   logic m_dir   = 1'b0;
   int   m_seg   = 0;
   int   m_limit = 0;
   logic [1:0] gray_tab [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

   encoder_control_system #(.STEP_PERIOD(STEP)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .enable_motor_in (enable_motor_in),
      .motor_dir_in    (motor_dir_in),
      .limit_value_in  (limit_value_in),
      .A_out           (A_out),
      .B_out           (B_out),
      .step_count_out  (step_count_out),
      .direction_out   (direction_out),
      .done_out        (done_out),
      .motor_dir_out   (motor_dir_out)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rst_n && done_out) done_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_A"}, A_out, 0);
      check({tag, "_B"}, B_out, 0);
      check({tag, "_count"}, step_count_out, 0);
      check({tag, "_direction"}, direction_out, 0);
      check({tag, "_done"}, done_out, 0);
      check({tag, "_motor_dir"}, motor_dir_out, 0);
   endtask

   task automatic model_complete();
      exp_done++;
      m_dir = ~m_dir;
      m_seg = 0;
   endtask

   // Waits for one quadrature step, then checks phase, decoded position and any segment completion.
   task automatic do_step(input string tag, output int waited);
      logic [1:0] prev_ab;
      bit seen;
      prev_ab = {A_out, B_out};
      seen = 0;
      waited = 0;
      for (int n = 1; n <= STEP + 10 && !seen; n++) begin
         @(negedge clk);
         if ({A_out, B_out} !== prev_ab) begin
            seen = 1;
            waited = n;
         end
      end
      check({tag, "_step_seen"}, seen, 1);
      if (seen) begin
         check({tag, "_drive_dir"}, motor_dir_out, m_dir);
         m_phase = m_dir ? (m_phase + 3) % 4 : (m_phase + 1) % 4;
         check({tag, "_ab"}, {A_out, B_out}, gray_tab[m_phase]);
         @(negedge clk);
         m_pos += m_dir ? -1 : 1;
         check({tag, "_count"}, step_count_out, m_pos);
         check({tag, "_direction"}, direction_out, m_dir);
         m_seg++;
         if (m_limit != 0 && m_seg >= m_limit) model_complete();
         repeat (3) @(negedge clk);
         check({tag, "_done_count"}, done_cnt, exp_done);
         check({tag, "_drive_dir_after"}, motor_dir_out, m_dir);
      end
   endtask

   task automatic run_steps(input string tag, input int n);
      int w;
      for (int i = 0; i < n; i++) do_step(tag, w);
   endtask

   // Applies direction command and limit together; a direction change pre-empts completion.
   task automatic set_inputs(input string tag, input logic dir, input int lim);
      bit dir_chg;
      dir_chg = (dir != motor_dir_in);
      motor_dir_in   = dir;
      limit_value_in = 8'(lim);
      m_limit = lim;
      if (dir_chg) begin
         m_dir = dir;
         m_seg = 0;
      end else if (lim != 0 && m_seg >= lim) begin
         model_complete();
      end
      @(negedge clk);
      check({tag, "_drive_dir"}, motor_dir_out, m_dir);
      @(negedge clk);
      check({tag, "_done_count"}, done_cnt, exp_done);
   endtask

   task automatic reset_pulse(input string tag);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check_all_zero(tag);
      motor_dir_in = 1'b0;
      m_pos = 0;
      m_phase = 0;
      m_dir = 1'b0;
      m_seg = 0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int w;
      logic [1:0]  frz_ab;
      logic [31:0] frz_count;
      bit frozen;

      rst_n = 1'b0;
      enable_motor_in = 1'b0;
      motor_dir_in = 1'b0;
      limit_value_in = 8'd0;
      #100;
      check_all_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("ab_after_reset", {A_out, B_out}, 2'b00);

      // Eight CW steps hit the limit, then the loop runs back CCW.
      limit_value_in = 8'd8;
      m_limit = 8;
      enable_motor_in = 1'b1;
      run_steps("cw_seg", 8);
      run_steps("auto_rev", 3);

      // Mid-run asynchronous reset, then a commanded reversal at count 3.
      reset_pulse("mid_reset");
      set_inputs("lim12", 1'b0, 12);
      run_steps("pre_rev", 3);
      set_inputs("cmd_rev", 1'b1, 12);
      run_steps("post_rev", 4);
      check("count_minus_one", step_count_out, 32'hFFFF_FFFF);

      // Lowering the limit below the current segment count fires immediately.
      run_steps("seg5", 1);
      set_inputs("lim_drop", 1'b1, 2);

      // Direction change in the same cycle the lowered limit would fire: no done.
      set_inputs("lim_off", 1'b1, 0);
      run_steps("prio_pre", 4);
      set_inputs("prio", 1'b0, 2);

      // Disable mid-period: outputs freeze, re-enable steps after one full period.
      run_steps("pre_hold", 1);
      repeat (20) @(negedge clk);
      enable_motor_in = 1'b0;
      @(negedge clk);
      frz_ab = {A_out, B_out};
      frz_count = step_count_out;
      frozen = 1;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if ({A_out, B_out} !== frz_ab || step_count_out !== frz_count || done_out !== 1'b0)
            frozen = 0;
      end
      check("hold_frozen", frozen, 1);
      check("hold_count", step_count_out, m_pos);
      enable_motor_in = 1'b1;
      do_step("reenable", w);
      check("reenable_latency", w, STEP);

      // Randomized segments: random limit, commanded direction and step count.
      for (int r = 0; r < 6; r++) begin
         set_inputs("rnd_cfg", 1'($urandom_range(1, 0)), int'($urandom_range(6, 1)));
         run_steps("rnd", int'($urandom_range(9, 1)));
      end

      // No limit: 300 CW steps from reset, no completion.
      reset_pulse("reset_nolimit");
      set_inputs("nolimit", 1'b0, 0);
      run_steps("nolimit", 300);
      check("nolimit_count", step_count_out, 32'd300);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
